quad_speed_meter: RTL and testbench

QUAD_SPEED_METER -- requirements
Module: quad_speed_meter

---
 rtl/quad_speed_meter.sv | 146 ++++++++++++++
 tb/tb_quad_speed_meter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_speed_meter.sv
// Quadrature encoder speed meter: decodes A/B steps into a saturating signed
// edge count per fixed gate window and reports magnitude, direction and errors.
module quad_speed_meter #(
    parameter int WINDOW = 500000
) (
    input  logic        theClock,
    input  logic        theReset,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enable,
    output logic [15:0] speed,
    output logic [7:0]  dir,
    output logic        valid,
    output logic [7:0]  err_cnt
);

    localparam int                TW       = 24;
    localparam logic [TW-1:0]     TMR_LOAD = TW'(WINDOW - 1);
    localparam logic signed [17:0] ACC_MAX = 18'sd131071;
    localparam logic signed [17:0] ACC_MIN = -18'sd131071;

    logic [1:0]         rst_sync_q;
    logic [1:0]         sync1_q, sync2_q, prev_q;
    logic               primed_q;
    logic               en_q;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic signed [17:0] acc_q, acc_d;
    logic [15:0]        speed_q, speed_d;
    logic [7:0]         dir_q, dir_d;
    logic               valid_q, valid_d;
    logic [7:0]         err_q, err_d;

    logic               active;
    logic               en_d;
    logic [1:0]         delta;
    logic               step_fwd, step_rev, step_bad;
    logic               win_end;
    logic signed [17:0] acc_step;
    logic [17:0]        acc_mag;
    logic [15:0]        speed_cap;
    logic [7:0]         dir_cap;

    // Position of an {A,B} pair along the forward sequence 00->10->11->01.
    function automatic logic [1:0] phase_of(input logic [1:0] ab);
        logic [1:0] p;
        case (ab)
            2'b00:   p = 2'd0;
            2'b10:   p = 2'd1;
            2'b11:   p = 2'd2;
            default: p = 2'd3;
        endcase
        return p;
    endfunction

    assign active = rst_sync_q[1];
    assign en_d   = enable & active;

    always_comb begin
        delta    = phase_of(sync2_q) - phase_of(prev_q);
        step_fwd = primed_q && (delta == 2'd1);
        step_rev = primed_q && (delta == 2'd3);
        step_bad = primed_q && (delta == 2'd2);
        win_end  = en_q && (tmr_q == '0);
    end

    always_comb begin
        acc_step = acc_q;
        if (step_fwd && (acc_q != ACC_MAX)) begin
            acc_step = acc_q + 18'sd1;
        end else if (step_rev && (acc_q != ACC_MIN)) begin
            acc_step = acc_q - 18'sd1;
        end
        acc_mag   = acc_step[17] ? 18'(-acc_step) : 18'(acc_step);
        speed_cap = (|acc_mag[17:16]) ? 16'hFFFF : acc_mag[15:0];
        if (acc_step == 18'sd0) begin
            dir_cap = 8'h00;
        end else if (acc_step[17]) begin
            dir_cap = 8'hFF;
        end else begin
            dir_cap = 8'h01;
        end
    end

    always_comb begin
        tmr_d   = tmr_q;
        acc_d   = acc_step;
        speed_d = speed_q;
        dir_d   = dir_q;
        valid_d = 1'b0;
        err_d   = err_q;
        if (!en_q || win_end) begin
            tmr_d = TMR_LOAD;
            acc_d = '0;
        end else begin
            tmr_d = tmr_q - 1'b1;
        end
        // The capture includes the step decoded on the window-end cycle itself.
        if (!enable) begin
            speed_d = '0;
            dir_d   = '0;
        end else if (win_end) begin
            speed_d = speed_cap;
            dir_d   = dir_cap;
            valid_d = 1'b1;
        end
        if (step_bad && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge theClock or negedge theReset) begin
        if (!theReset) begin
            rst_sync_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            primed_q   <= 1'b0;
            en_q       <= 1'b0;
            tmr_q      <= TMR_LOAD;
            acc_q      <= '0;
            speed_q    <= '0;
            dir_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            sync1_q    <= {enc_a, enc_b};
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            primed_q   <= active;
            en_q       <= en_d;
            tmr_q      <= tmr_d;
            acc_q      <= acc_d;
            speed_q    <= speed_d;
            dir_q      <= dir_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign speed   = speed_q;
    assign dir     = dir_q;
    assign valid   = valid_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_quad_speed_meter.sv
// Directed bench for quad_speed_meter: a WINDOW=100 instance for window timing,
// direction, errors and reset, plus a long-window instance for speed saturation.
module tb_quad_speed_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a0, b0, en0, a1, b1, en1;
    logic [15:0] speed0, speed1;
    logic [7:0]  dir0, dir1, err0, err1;
    logic        valid0, valid1;

    int checks   = 0;
    int failures = 0;
    int st0 = 0;
    int st1 = 0;

    always #5 clk = ~clk;

    quad_speed_meter #(.WINDOW(100)) u_dut0 (
        .theClock(clk), .theReset(rst_n), .enc_a(a0), .enc_b(b0), .enable(en0),
        .speed(speed0), .dir(dir0), .valid(valid0), .err_cnt(err0)
    );

    quad_speed_meter #(.WINDOW(65538)) u_dut1 (
        .theClock(clk), .theReset(rst_n), .enc_a(a1), .enc_b(b1), .enable(en1),
        .speed(speed1), .dir(dir1), .valid(valid1), .err_cnt(err1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] gray_of(input int s);
        logic [1:0] ab;
        case (s)
            0:       ab = 2'b00;
            1:       ab = 2'b10;
            2:       ab = 2'b11;
            default: ab = 2'b01;
        endcase
        return ab;
    endfunction

    task automatic step0(input int d);
        st0 = (st0 + d + 4) % 4;
        {a0, b0} = gray_of(st0);
    endtask

    task automatic step1();
        st1 = (st1 + 1) % 4;
        {a1, b1} = gray_of(st1);
    endtask

    task automatic steps0(input int n, input int d, input int gap);
        for (int i = 0; i < n; i++) begin
            step0(d);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_valid0(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (valid0) got = 1'b1;
        end
        if (!got) check_eq({tag, "_timeout"}, 32'(valid0), 32'd1);
    endtask

    initial begin
        int  vcnt;
        int  jv;
        bit  done;

        rst_n = 1'b0;
        en0   = 1'b0;
        en1   = 1'b0;
        st0   = 2;
        {a0, b0} = gray_of(st0);
        {a1, b1} = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(valid0), 32'd0);
        check_eq("rst_speed", 32'(speed0), 32'd0);
        check_eq("rst_dir",   32'(dir0),   32'd0);
        check_eq("rst_err",   32'(err0),   32'd0);

        // Pins rest at 11 through reset release: no step or error may appear.
        en0   = 1'b1;
        rst_n = 1'b1;
        wait_valid0("first");
        check_eq("first_speed", 32'(speed0), 32'd0);
        check_eq("first_dir",   32'(dir0),   32'd0);
        check_eq("first_err",   32'(err0),   32'd0);

        steps0(40, 1, 2);
        wait_valid0("fwd40");
        check_eq("fwd40_speed", 32'(speed0), 32'd40);
        check_eq("fwd40_dir",   32'(dir0),   32'h01);

        steps0(25, -1, 2);
        wait_valid0("rev25");
        check_eq("rev25_speed", 32'(speed0), 32'd25);
        check_eq("rev25_dir",   32'(dir0),   32'hFF);
        wait_valid0("idle");
        check_eq("idle_speed", 32'(speed0), 32'd0);
        check_eq("idle_dir",   32'(dir0),   32'h00);
        @(negedge clk);
        check_eq("valid_width", 32'(valid0), 32'd0);

        // Window end is 99 cycles after a valid cycle; decode lands 2 cycles after a pin change.
        wait_valid0("sync_c");
        repeat (97) @(negedge clk);
        step0(1);
        @(negedge clk);
        step0(1);
        wait_valid0("edge_n");
        check_eq("edge_n_speed", 32'(speed0), 32'd1);
        check_eq("edge_n_dir",   32'(dir0),   32'h01);
        wait_valid0("edge_n1");
        check_eq("edge_n1_speed", 32'(speed0), 32'd1);
        check_eq("edge_n1_dir",   32'(dir0),   32'h01);

        steps0(10, 1, 2);
        repeat (5) @(negedge clk);
        en0 = 1'b0;
        @(negedge clk);
        check_eq("dis_speed", 32'(speed0), 32'd0);
        check_eq("dis_dir",   32'(dir0),   32'd0);
        vcnt = 0;
        for (int j = 1; j <= 150; j++) begin
            @(negedge clk);
            if (valid0) vcnt++;
            if (j == 10 || j == 12 || j == 14) step0(1);
        end
        check_eq("dis_valid_cnt", 32'(vcnt),   32'd0);
        check_eq("dis_speed_end", 32'(speed0), 32'd0);

        en0  = 1'b1;
        vcnt = 0;
        for (int j = 1; j <= 101; j++) begin
            @(negedge clk);
            if (j < 101 && valid0) vcnt++;
            if (j >= 3 && j <= 13 && (j % 2) == 1) step0(1);
        end
        check_eq("reen_valid",     32'(valid0), 32'd1);
        check_eq("reen_early_cnt", 32'(vcnt),   32'd0);
        check_eq("reen_speed",     32'(speed0), 32'd6);
        check_eq("reen_dir",       32'(dir0),   32'h01);

        check_eq("err_pre", 32'(err0), 32'd0);
        for (int i = 0; i < 100; i++) begin
            st0 = (st0 + 2) % 4;
            {a0, b0} = gray_of(st0);
            repeat (2) @(negedge clk);
        end
        @(negedge clk);
        check_eq("err_100", 32'(err0), 32'd100);
        for (int i = 0; i < 200; i++) begin
            st0 = (st0 + 2) % 4;
            {a0, b0} = gray_of(st0);
            repeat (2) @(negedge clk);
        end
        @(negedge clk);
        check_eq("err_sat", 32'(err0), 32'hFF);
        wait_valid0("err_w1");
        wait_valid0("err_w2");
        check_eq("err_speed", 32'(speed0), 32'd0);
        check_eq("err_dir",   32'(dir0),   32'd0);

        steps0(5, 1, 2);
        wait_valid0("fwd5");
        check_eq("fwd5_speed", 32'(speed0), 32'd5);
        check_eq("fwd5_dir",   32'(dir0),   32'h01);

        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_err",   32'(err0),   32'd0);
        check_eq("arst_speed", 32'(speed0), 32'd0);
        check_eq("arst_dir",   32'(dir0),   32'd0);
        check_eq("arst_valid", 32'(valid0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid0("post_rst");
        check_eq("post_rst_speed", 32'(speed0), 32'd0);
        check_eq("post_rst_err",   32'(err0),   32'd0);

        steps0(7, 1, 2);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid0("mid_rst");
        check_eq("mid_rst_speed", 32'(speed0), 32'd0);

        // Step every cycle across a whole 65538-cycle window: must clamp, not wrap to 2.
        for (int i = 0; i < 5; i++) begin
            step1();
            @(negedge clk);
        end
        en1  = 1'b1;
        step1();
        done = 1'b0;
        jv   = 0;
        for (int j = 1; j <= 66000 && !done; j++) begin
            @(negedge clk);
            if (valid1) begin
                done = 1'b1;
                jv   = j;
            end else begin
                step1();
            end
        end
        check_eq("sat_latency", 32'(jv),     32'd65539);
        check_eq("sat_speed",   32'(speed1), 32'hFFFF);
        check_eq("sat_dir",     32'(dir1),   32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
